// File: rtl/sd_dat_rx_1bit.sv
// Card-side SDIO write-block receiver on DAT0 (1-bit mode): deserialises one block,
// checks CRC16 and end bit, then returns the CRC status token and busy on DAT0.
module sd_dat_rx_1bit #(
  parameter int LEN_BITS = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [LEN_BITS-1:0] block_len,
  input  logic                abort,
  input  logic                busy_in,
  input  logic                dat_in,
  output logic                dat_out,
  output logic                dat_oe,
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic                done,
  output logic                crc_ok,
  output logic                active,
  output logic [3:0]          dbg_state
);

  localparam int CW = LEN_BITS + 3;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_GAP, S_TOKEN, S_BUSY, S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [15:0]         crc_calc_q, crc_calc_d;
  logic [15:0]         crc_rx_q, crc_rx_d;
  logic [2:0]          status_q, status_d;
  logic                dat_out_q, dat_out_d;
  logic                dat_oe_q, dat_oe_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                done_q, done_d;
  logic                crc_ok_q, crc_ok_d;

  logic                crc_x;
  logic [15:0]         crc_step;
  logic [CW-1:0]       last_bit;
  logic                blk_good;

  assign crc_x    = dat_in ^ crc_calc_q[15];
  assign crc_step = {crc_calc_q[14:0], crc_x} ^ (crc_x ? 16'h1020 : 16'h0000);
  assign last_bit = {len_q - LEN_BITS'(1), 3'b111};
  assign blk_good = (crc_rx_q == crc_calc_q) && dat_in;

  // data_valid is a 1-cycle strobe with no back-pressure: the consumer must take
  // data_out in the cycle data_valid is high, as the next byte overwrites it.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    crc_calc_d   = crc_calc_q;
    crc_rx_d     = crc_rx_q;
    status_d     = status_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    crc_ok_d     = crc_ok_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (block_len != '0)) begin
            state_d    = S_WAIT_START;
            len_d      = block_len;
            crc_calc_d = 16'h0000;
            bit_cnt_d  = '0;
            cnt_d      = 4'd0;
            crc_ok_d   = 1'b0;
          end
        end
        S_WAIT_START: if (!dat_in) state_d = S_DATA;
        S_DATA: begin
          shift_d    = {shift_q[5:0], dat_in};
          crc_calc_d = crc_step;
          bit_cnt_d  = bit_cnt_q + CW'(1);
          if (bit_cnt_q[2:0] == 3'd7) begin
            data_out_d   = {shift_q, dat_in};
            data_valid_d = 1'b1;
          end
          if (bit_cnt_q == last_bit) begin
            state_d = S_CRC;
            cnt_d   = 4'd0;
          end
        end
        S_CRC: begin
          crc_rx_d = {crc_rx_q[14:0], dat_in};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_END;
        end
        S_END: begin
          status_d = blk_good ? 3'b010 : 3'b101;
          crc_ok_d = blk_good;
          cnt_d    = 4'd0;
          state_d  = S_GAP;
        end
        S_GAP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_TOKEN;
            cnt_d   = 4'd0;
          end
        end
        S_TOKEN: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd4) state_d = (status_q == 3'b010) ? S_BUSY : S_IDLE;
        end
        S_BUSY:    if (!busy_in) state_d = S_RELEASE;
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    // Pad outputs are derived from the next state so they line up with it once registered.
    dat_oe_d  = (state_d == S_TOKEN) || (state_d == S_BUSY) || (state_d == S_RELEASE);
    dat_out_d = 1'b1;
    if (state_d == S_TOKEN) begin
      case (cnt_d)
        4'd0:    dat_out_d = 1'b0;
        4'd1:    dat_out_d = status_d[2];
        4'd2:    dat_out_d = status_d[1];
        4'd3:    dat_out_d = status_d[0];
        default: dat_out_d = 1'b1;
      endcase
    end else if (state_d == S_BUSY) begin
      dat_out_d = 1'b0;
    end
    done_d = (state_d == S_RELEASE) ||
             ((state_d == S_TOKEN) && (cnt_d == 4'd4) && (status_d != 3'b010));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      cnt_q        <= 4'd0;
      shift_q      <= 7'd0;
      crc_calc_q   <= 16'h0000;
      crc_rx_q     <= 16'h0000;
      status_q     <= 3'b101;
      dat_out_q    <= 1'b1;
      dat_oe_q     <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      crc_calc_q   <= crc_calc_d;
      crc_rx_q     <= crc_rx_d;
      status_q     <= status_d;
      dat_out_q    <= dat_out_d;
      dat_oe_q     <= dat_oe_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      crc_ok_q     <= crc_ok_d;
    end
  end

  assign dat_out    = dat_out_q;
  assign dat_oe     = dat_oe_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign crc_ok     = crc_ok_q;
  assign active     = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_dat_rx_1bit.sv
// Bench for sd_dat_rx_1bit: table of block transactions plus random blocks against a
// byte-wise CRC16 reference, and hand-written abort / reset / ignored-start sequences.
module tb_sd_dat_rx_1bit;
  localparam int LEN_BITS = 10;

  logic                clock = 1'b0;
  logic                reset_n, start, abort, busy_in, dat_in;
  logic [LEN_BITS-1:0] block_len;
  logic                dat_out, dat_oe, data_valid, done, crc_ok, active;
  logic [7:0]          data_out;
  logic [3:0]          dbg_state;

  sd_dat_rx_1bit #(.LEN_BITS(LEN_BITS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .block_len(block_len),
    .abort(abort), .busy_in(busy_in), .dat_in(dat_in), .dat_out(dat_out),
    .dat_oe(dat_oe), .data_out(data_out), .data_valid(data_valid), .done(done),
    .crc_ok(crc_ok), .active(active), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int         checks = 0, errors = 0;
  int         n_strobe = 0, n_done = 0, exp_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] blk[0:1023];

  typedef struct {
    int          len;
    int          pat;       // 0: constant fill, 1: random bytes
    logic [7:0]  fill;
    int          crc_mode;  // 0: literal crc_val, 1: reference CRC, 2: reference CRC with one bit flipped
    logic [15:0] crc_val;
    logic        end_bit;
    int          busy_n;
    logic        repulse;
    logic [2:0]  exp_status;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[13];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Byte-at-a-time CCITT reference: message byte folded into the top of the register.
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      c = c ^ {blk[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge clock) begin
    if (reset_n && data_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) check("unexpected_byte", data_out, 32'hFFFF_FFFF);
      else check("rx_byte", data_out, exp_q.pop_front());
    end
    if (reset_n && done) n_done++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_block(input vec_t v);
    logic [15:0] rxc;
    logic [3:0]  ev[$];
    logic        tok[5];
    logic        good;
    int          s0;
    for (int i = 0; i < v.len; i++) begin
      blk[i] = (v.pat == 1) ? 8'($urandom) : v.fill;
      exp_q.push_back(blk[i]);
    end
    case (v.crc_mode)
      0:       rxc = v.crc_val;
      1:       rxc = model_crc(v.len);
      default: rxc = model_crc(v.len) ^ (16'h0001 << $urandom_range(0, 15));
    endcase
    s0 = n_strobe;
    start = 1'b1; block_len = LEN_BITS'(v.len);
    step();
    start = 1'b0;
    check("accept", {active, crc_ok}, 2'b10);
    dat_in = 1'b1;
    repeat ($urandom_range(0, 3)) step();
    dat_in = 1'b0;
    step();
    for (int i = 0; i < v.len; i++) begin
      for (int b = 7; b >= 0; b--) begin
        dat_in = blk[i][b];
        if (v.repulse && i == 0 && b == 3) begin
          start = 1'b1; block_len = LEN_BITS'(5);
        end
        step();
        start = 1'b0;
      end
    end
    for (int b = 15; b >= 0; b--) begin
      dat_in = rxc[b];
      step();
    end
    dat_in = v.end_bit; busy_in = 1'b1;
    step();
    dat_in = 1'b1;
    good = (v.exp_status == 3'b010);
    tok[0] = 1'b0; tok[1] = v.exp_status[2]; tok[2] = v.exp_status[1];
    tok[3] = v.exp_status[0]; tok[4] = 1'b1;
    // expected {dat_oe, dat_out, done, active} per cycle from the first gap cycle
    ev.push_back(4'b0101);
    ev.push_back(4'b0101);
    for (int k = 0; k < 5; k++) ev.push_back({1'b1, tok[k], (k == 4) && !good, 1'b1});
    if (good) begin
      for (int k = 0; k < v.busy_n; k++) ev.push_back(4'b1001);
      ev.push_back(4'b1111);
    end
    ev.push_back(4'b0100);
    for (int j = 0; j < ev.size(); j++) begin
      check("resp", {dat_oe, dat_out, done, active}, ev[j]);
      if (good && j >= 7 && j < 7 + v.busy_n) busy_in = ((j - 6) < v.busy_n);
      if (j != ev.size() - 1) step();
    end
    busy_in = 1'b0;
    exp_done++;
    check("crc_ok", crc_ok, v.exp_ok);
    check("strobes", n_strobe - s0, v.len);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] c;
    vec_t        g;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; busy_in = 1'b0; dat_in = 1'b1;
    block_len = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset", {dat_out, dat_oe, data_out, data_valid, done, crc_ok, active}, 14'b10_00000000_0000);
    @(negedge clock) reset_n = 1'b1;
    step();

    vecs[0] = '{512, 0, 8'hFF, 0, 16'h7FA1, 1'b1, 1,  1'b0, 3'b010, 1'b1};
    vecs[1] = '{4,   0, 8'h00, 0, 16'h0000, 1'b1, 10, 1'b0, 3'b010, 1'b1};
    vecs[2] = '{512, 0, 8'hFF, 0, 16'h7FA0, 1'b1, 1,  1'b0, 3'b101, 1'b0};
    vecs[3] = '{6,   1, 8'h00, 1, 16'h0000, 1'b0, 1,  1'b0, 3'b101, 1'b0};
    vecs[4] = '{1,   0, 8'hA5, 1, 16'h0000, 1'b1, 2,  1'b1, 3'b010, 1'b1};
    for (int i = 5; i < 13; i++) begin
      vecs[i].len        = $urandom_range(1, 24);
      vecs[i].pat        = 1;
      vecs[i].fill       = 8'h00;
      vecs[i].crc_mode   = $urandom_range(1, 2);
      vecs[i].crc_val    = 16'h0000;
      vecs[i].end_bit    = ($urandom_range(0, 3) != 0);
      vecs[i].busy_n     = $urandom_range(1, 6);
      vecs[i].repulse    = 1'($urandom_range(0, 1));
      vecs[i].exp_ok     = (vecs[i].crc_mode == 1) && vecs[i].end_bit;
      vecs[i].exp_status = vecs[i].exp_ok ? 3'b010 : 3'b101;
    end
    for (int i = 0; i < 13; i++) run_block(vecs[i]);

    // known-good block so crc_ok=1 going into the corner cases
    g = '{2, 1, 8'h00, 1, 16'h0000, 1'b1, 3, 1'b0, 3'b010, 1'b1};
    run_block(g);

    start = 1'b1; abort = 1'b1; block_len = LEN_BITS'(3);
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", {active, crc_ok}, 2'b01);
    start = 1'b1; block_len = '0;
    step();
    start = 1'b0; dat_in = 1'b0;
    repeat (3) step();
    check("len0_ignored", {active, crc_ok, done}, 3'b010);

    dat_in = 1'b1; start = 1'b1; block_len = LEN_BITS'(4);
    step();
    start = 1'b0; dat_in = 1'b0;
    step();
    for (int b = 0; b < 5; b++) begin
      dat_in = 1'($urandom);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_mid_data", {active, dat_oe, dat_out, done, crc_ok}, 5'b00100);
    for (int b = 0; b < 6; b++) begin
      dat_in = 1'($urandom);
      step();
    end
    check("idle_after_abort", {active, dat_oe, done}, 3'b000);

    blk[0] = 8'h5A;
    exp_q.push_back(8'h5A);
    c = model_crc(1);
    dat_in = 1'b1; start = 1'b1; block_len = LEN_BITS'(1);
    step();
    start = 1'b0; dat_in = 1'b0;
    step();
    for (int b = 7; b >= 0; b--) begin
      dat_in = blk[0][b];
      step();
    end
    for (int b = 15; b >= 0; b--) begin
      dat_in = c[b];
      step();
    end
    dat_in = 1'b1;
    step();
    repeat (4) step();
    check("token_oe", {dat_oe, crc_ok, data_out}, {1'b1, 1'b1, 8'h5A});
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_token", {dat_out, dat_oe, data_out, data_valid, done, crc_ok, active}, 14'b10_00000000_0000);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) step();
    check("idle_after_reset", {active, dat_oe, dat_out, done}, 4'b0010);

    check("done_count", n_done, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
